instr_encode_loader: RTL and testbench

Sequential instruction encoder and loader, the write-side counterpart of the processor's opcode decode stage. It accepts instruction field bundles (kind, rd, rs, rt, shamt, aluop, imm) over a valid/ready handshake. It packs each bundle into the 32-bit instruction word format that the decode stage consumes, and writes the words into instruction memory at consecutive addresses starting from a programmable base. It sits between the test/boot host and the imem write port, and runs once per `start` for a programmed word count.

---
 rtl/instr_encode_loader_pkg.sv | 33 +++
 rtl/instr_encode_loader_field_pack.sv | 44 ++++
 rtl/instr_encode_loader.sv | 98 +++++++++
 tb/tb_instr_encode_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instr_encode_loader_pkg.sv
// Shared processor encoding: opcodes, kind codes and instruction field positions,
// kept identical to what the decode stage uses.
package instr_encode_loader_pkg;

  localparam int INSTR_W = 32;

  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;

  typedef enum logic [2:0] {
    KIND_ALU  = 3'd0,
    KIND_ADDI = 3'd1,
    KIND_SW   = 3'd2,
    KIND_LW   = 3'd3
  } kind_e;

  localparam int OPC_HI   = 31, OPC_LO   = 27;
  localparam int RD_HI    = 26, RD_LO    = 22;
  localparam int RS_HI    = 21, RS_LO    = 17;
  localparam int RT_HI    = 16, RT_LO    = 12;
  localparam int SHAMT_HI = 11, SHAMT_LO = 7;
  localparam int ALUOP_HI = 6,  ALUOP_LO = 2;
  localparam int IMM_HI   = 16, IMM_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/instr_encode_loader_field_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit word and a legal flag.
module instr_field_pack
  import instr_encode_loader_pkg::*;
(
  input  logic [2:0]         kind,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         shamt,
  input  logic [4:0]         aluop,
  input  logic [16:0]        imm,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  logic [4:0] opc;

  always_comb begin
    opc   = OPC_ALU;
    legal = 1'b1;
    case (kind)
      KIND_ALU:  opc = OPC_ALU;
      KIND_ADDI: opc = OPC_ADDI;
      KIND_SW:   opc = OPC_SW;
      KIND_LW:   opc = OPC_LW;
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    word                  = '0;
    word[OPC_HI:OPC_LO]   = opc;
    word[RD_HI:RD_LO]     = rd;
    word[RS_HI:RS_LO]     = rs;
    if (kind == KIND_ALU) begin
      word[RT_HI:RT_LO]       = rt;
      word[SHAMT_HI:SHAMT_LO] = shamt;
      word[ALUOP_HI:ALUOP_LO] = aluop;
    end else begin
      word[IMM_HI:IMM_LO]     = imm;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Loader FSM: accepts field bundles, packs them and writes consecutive imem words
// starting at a latched base address, for a latched word count.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [ADDR_W-1:0]  ptr;
  logic [INSTR_W-1:0] pack_word;
  logic               pack_legal;
  logic               hs, hs_ok, start_ok;

  instr_field_pack u_pack (
    .kind  (in_kind),
    .rd    (in_rd),
    .rs    (in_rs),
    .rt    (in_rt),
    .shamt (in_shamt),
    .aluop (in_aluop),
    .imm   (in_imm),
    .word  (pack_word),
    .legal (pack_legal)
  );

  // Ready depends on registered state only, never on in_valid.
  assign in_ready = (state == ST_RUN) && (remaining != '0);
  assign hs       = in_valid && in_ready;
  assign hs_ok    = hs && pack_legal;
  assign start_ok = (state == ST_IDLE) && start;
  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign done     = (state == ST_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (hs_ok && remaining == CNT_W'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      ptr       <= '0;
      err       <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (start_ok) begin
        remaining <= count;
        ptr       <= base_addr;
        err       <= 1'b0;
      end
      // Illegal bundles are swallowed: flagged, but neither written nor counted.
      if (hs_ok) begin
        imem_we   <= 1'b1;
        imem_addr <= ptr;
        imem_data <= pack_word;
        remaining <= remaining - 1'b1;
        ptr       <= ptr + 1'b1;
      end else if (hs) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with hand-computed instruction words.
module tb_instr_encode_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [16:0] in_imm;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;

  instr_encode_loader #(.ADDR_W(12), .CNT_W(12)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_aluop(in_aluop),
    .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (imem_we === 1'b1) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                      input logic [16:0] imm);
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = op; in_imm = imm;
  endtask

  task automatic go(input logic [11:0] b, input logic [11:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_kind = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_shamt = '0; in_aluop = '0; in_imm = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_outputs", {23'd0, in_ready, imem_we, busy, done, err, 4'd0}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    tick();

    // ALU then ADDI at base 0x010
    go(12'h010, 12'd2);
    chk("t1_busy_ready", {30'd0, busy, in_ready}, 32'd3);
    send(3'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0);
    tick();
    chk("t1_we0", 32'(imem_we), 32'd1);
    chk("t1_addr0", 32'(imem_addr), 32'h010);
    chk("t1_data0", imem_data, 32'h00C22000); // (3<<22)|(1<<17)|(2<<12)
    chk("t1_done_early", 32'(done), 32'd0);
    send(3'd1, 5'd4, 5'd3, 5'd0, 5'd0, 5'd0, 17'h00005);
    tick();
    in_valid = 1'b0;
    chk("t1_we1", 32'(imem_we), 32'd1);
    chk("t1_addr1", 32'(imem_addr), 32'h011);
    chk("t1_data1", imem_data, 32'h29060005);
    chk("t1_done_busy_ready", {29'd0, done, busy, in_ready}, 32'd6);
    tick();
    chk("t1_idle", {29'd0, done, busy, imem_we}, 32'd0);
    chk("t1_addr_hold", 32'(imem_addr), 32'h011);

    // SW / LW back to back
    go(12'h020, 12'd2);
    send(3'd2, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 17'h1FFFF);
    tick();
    chk("t2_sw", {imem_we ? 32'h1 : 32'h0} ^ 32'h1 | (imem_data ^ 32'h394DFFFF), 32'd0);
    chk("t2_sw_addr", 32'(imem_addr), 32'h020);
    send(3'd3, 5'd7, 5'd6, 5'd0, 5'd0, 5'd0, 17'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_lw_we", 32'(imem_we), 32'd1);
    chk("t2_lw", imem_data, 32'h41CC0000);
    chk("t2_lw_addr", 32'(imem_addr), 32'h021);
    tick();

    // address wrap
    go(12'hFFF, 12'd2);
    send(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1);
    tick();
    chk("t3_addr_fff", 32'(imem_addr), 32'hFFF);
    tick();
    in_valid = 1'b0;
    chk("t3_addr_wrap", 32'(imem_addr), 32'h000);
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_writes", 32'(wr_cnt), 32'd6);

    // illegal kind, then a legal LW; start during RUN ignored
    go(12'h100, 12'd1);
    send(3'd5, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'd9);
    tick();
    chk("t4_illegal", {29'd0, imem_we, err, in_ready}, 32'd3);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'h00010);
    start = 1'b1; count = 12'd5;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("t4_lw", imem_data, 32'h40440010);
    chk("t4_flags", {29'd0, imem_we, done, err}, 32'd7);
    tick();
    chk("t4_err_sticky", {30'd0, busy, err}, 32'd1);
    chk("t4_writes", 32'(wr_cnt), 32'd7);

    // count=0: done next cycle, no writes, err cleared
    go(12'h050, 12'd0);
    chk("t5_drain", {28'd0, done, busy, imem_we, err}, 32'hC);
    tick();
    chk("t5_idle", {29'd0, done, busy, in_ready}, 32'd0);
    tick();
    chk("t5_writes", 32'(wr_cnt), 32'd7);

    // reset right after a handshake, before the write is seen
    go(12'h200, 12'd2);
    send(3'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd0);
    @(posedge clock);
    reset = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("t6_rst_flags", {26'd0, in_ready, imem_we, busy, done, err, 1'b0}, 32'd0);
    chk("t6_rst_addr", 32'(imem_addr), 32'd0);
    chk("t6_rst_data", imem_data, 32'd0);
    tick();
    reset = 1'b0;
    chk("t6_no_write", 32'(wr_cnt), 32'd7);
    go(12'h300, 12'd1);
    send(3'd3, 5'd7, 5'd6, 5'd0, 5'd0, 5'd0, 17'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_after_addr", 32'(imem_addr), 32'h300);
    chk("t6_after_data", imem_data, 32'h41CC0000);
    chk("t6_after_done", {30'd0, imem_we, done}, 32'd3);
    tick();
    chk("t6_writes", 32'(wr_cnt), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
